load_seq_ctrl: RTL and testbench

Sequencing controller for data-memory loads. It accepts one load request at a time from the core, issues one or two word-aligned reads to data memory over a request/grant/response-valid handshake, and merges the returned words. It then selects and sign- or zero-extends the addressed byte, halfword or word, and holds the result until the core accepts it. It sits between the execute stage and the data memory, and replaces the purely combinational load extension for accesses that can stall or cross a word boundary.

---
 rtl/load_seq_ctrl_if.sv | 39 +++
 rtl/load_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_load_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_seq_ctrl_if.sv
// Core-side load request/response and data-memory read handshake for
// load_seq_ctrl. The controller takes the slave view; whatever drives
// requests and answers memory reads takes the master view.
interface load_seq_ctrl_if #(
    parameter int ADDR_W = 32
);
    // core request
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    // data memory read port
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    // core response
    logic              rsp_valid_o;
    logic [31:0]       rsp_data_o;
    logic              rsp_err_o;
    logic              rsp_ready_i;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_size_i, req_unsigned_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, rsp_ready_i,
        output req_ready_o, mem_req_o, mem_addr_o,
        output rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_size_i, req_unsigned_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, rsp_ready_i,
        input  req_ready_o, mem_req_o, mem_addr_o,
        input  rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/load_seq_ctrl.sv
// Load sequencing controller: accepts one load at a time, issues one or two
// word-aligned memory reads, merges the words and sign/zero-extends the
// addressed byte, halfword or word, holding the result until accepted.
//
// Build option: define MISALIGN_SPLIT_EN to run word-crossing accesses as two
// sequential reads. Without it, crossing accesses return an error response
// and never touch memory.
module load_seq_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    load_seq_ctrl_if.slave bus
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
`ifdef MISALIGN_SPLIT_EN
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
`endif
        RESP  = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              err_q;
    logic [31:0]       lo_q;
    // Only the low three bytes of the second word can ever reach the result.
    logic [23:0]       hi_q;

    logic              req_err;
    logic [ADDR_W-3:0] word_q;
    logic [ADDR_W-3:0] word_nxt;
    logic [31:0]       merged;
    logic [31:0]       ext_data;

    // True when offset + access bytes runs past the end of the word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] bytes;
        unique case (size)
            SZ_BYTE: bytes = 4'd1;
            SZ_HALF: bytes = 4'd2;
            SZ_WORD: bytes = 4'd4;
            default: bytes = 4'd0;
        endcase
        return ({2'b00, off} + bytes) > 4'd4;
    endfunction

`ifdef MISALIGN_SPLIT_EN
    assign req_err = (bus.req_size_i == SZ_ILL);
`else
    assign req_err = (bus.req_size_i == SZ_ILL) |
                     crosses(bus.req_addr_i[1:0], bus.req_size_i);
`endif

    assign word_q   = addr_q[ADDR_W-1:2];
    assign word_nxt = word_q + {{(ADDR_W-3){1'b0}}, 1'b1};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.req_valid_i) state_d = req_err ? RESP : REQ0;
            REQ0:  if (bus.mem_gnt_i)   state_d = WAIT0;
            WAIT0: begin
                if (bus.mem_rvalid_i) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = crosses(addr_q[1:0], size_q) ? REQ1 : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1:  if (bus.mem_gnt_i)    state_d = WAIT1;
            WAIT1: if (bus.mem_rvalid_i) state_d = RESP;
`endif
            RESP:  if (bus.rsp_ready_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data latching.
    // NOTE: these are a handful of plain flops, not a memory array, so all of
    // them are reset; that keeps a post-reset response path at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q     <= bus.req_addr_i;
                        size_q     <= bus.req_size_i;
                        unsigned_q <= bus.req_unsigned_i;
                        err_q      <= req_err;
                        lo_q       <= '0;
                        hi_q       <= '0;
                    end
                end
                WAIT0: if (bus.mem_rvalid_i) lo_q <= bus.mem_rdata_i;
`ifdef MISALIGN_SPLIT_EN
                WAIT1: if (bus.mem_rvalid_i) hi_q <= bus.mem_rdata_i[23:0];
`endif
                default: ;
            endcase
        end
    end

    // Merge {hi, lo} shifted down by the byte offset, then extend by size.
    always_comb begin
        merged = lo_q;
        unique case (addr_q[1:0])
            2'd0: merged = lo_q;
            2'd1: merged = {hi_q[7:0],  lo_q[31:8]};
            2'd2: merged = {hi_q[15:0], lo_q[31:16]};
            2'd3: merged = {hi_q[23:0], lo_q[31:24]};
            default: merged = lo_q;
        endcase
        unique case (size_q)
            SZ_BYTE: ext_data = unsigned_q ? {24'd0, merged[7:0]}
                                           : {{24{merged[7]}}, merged[7:0]};
            SZ_HALF: ext_data = unsigned_q ? {16'd0, merged[15:0]}
                                           : {{16{merged[15]}}, merged[15:0]};
            default: ext_data = merged;
        endcase
    end

    // Output decode from state and latched registers only.
    always_comb begin
        bus.req_ready_o = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_addr_o  = '0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_data_o  = '0;
        bus.rsp_err_o   = 1'b0;
        bus.busy_o      = (state_q != IDLE);
        unique case (state_q)
            IDLE: bus.req_ready_o = 1'b1;
            REQ0: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {word_q, 2'b00};
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {word_nxt, 2'b00};
            end
`endif
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_err_o   = err_q;
                bus.rsp_data_o  = err_q ? 32'd0 : ext_data;
            end
            default: ;
        endcase
    end

`ifndef MISALIGN_SPLIT_EN
    // The second-word address only exists in the split build.
    logic unused_word_nxt;
    assign unused_word_nxt = ^word_nxt;
`endif

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Directed bench for load_seq_ctrl: a small memory responder with per-read
// grant delay, response backpressure, split/wrap/illegal accesses and a reset
// in the middle of a read. Expectations follow the MISALIGN_SPLIT_EN build.
module tb_load_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    load_seq_ctrl_if #(.ADDR_W(32)) bus ();

    load_seq_ctrl #(.ADDR_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // memory contents for the current test
    logic [31:0] mem_a0, mem_d0, mem_a1, mem_d1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == mem_a0) return mem_d0;
        if (a == mem_a1) return mem_d1;
        return 32'hDEAD_BEEF;
    endfunction

    // results of the last run_load
    int          r_cycle;
    logic [31:0] r_data;
    logic        r_err;
    int          r_nreads;
    logic [31:0] r_addr0, r_addr1;
    logic        r_unstable;
    logic        r_done;

    task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input int gnt_dly1, input int rdy_dly);
        int          c;
        int          rd;
        int          wait_cnt;
        int          rdy_cnt;
        logic        pend;
        logic [31:0] pend_data;
        logic        req_active;
        logic [31:0] held_addr;
        r_cycle = -1; r_data = '0; r_err = 1'b0; r_nreads = 0;
        r_addr0 = '0; r_addr1 = '0; r_unstable = 1'b0; r_done = 1'b0;
        c = 0; rd = 0; wait_cnt = 0; rdy_cnt = rdy_dly;
        pend = 1'b0; pend_data = '0; req_active = 1'b0; held_addr = '0;

        @(negedge clk);
        check({name, ".ready_in"}, {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        @(posedge clk);  // acceptance edge, cycle 0

        while (!r_done && c < 40) begin
            @(negedge clk);
            c++;
            bus.req_valid_i  = 1'b0;
            bus.mem_rvalid_i = pend;
            bus.mem_rdata_i  = pend ? pend_data : 32'h0;
            pend             = 1'b0;
            bus.mem_gnt_i    = 1'b0;
            bus.rsp_ready_i  = 1'b0;
            if (bus.mem_req_o) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    held_addr  = bus.mem_addr_o;
                    wait_cnt   = (rd == 1) ? gnt_dly1 : 0;
                end
                if (bus.mem_addr_o !== held_addr) r_unstable = 1'b1;
                if (wait_cnt == 0) begin
                    bus.mem_gnt_i = 1'b1;
                    if (rd == 0) r_addr0 = bus.mem_addr_o;
                    else         r_addr1 = bus.mem_addr_o;
                    pend       = 1'b1;
                    pend_data  = mem_word(bus.mem_addr_o);
                    rd++;
                    req_active = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            if (bus.rsp_valid_o) begin
                if (r_cycle < 0) begin
                    r_cycle = c;
                    r_data  = bus.rsp_data_o;
                    r_err   = bus.rsp_err_o;
                end else if (bus.rsp_data_o !== r_data || bus.rsp_err_o !== r_err) begin
                    r_unstable = 1'b1;
                end
                if (rdy_cnt == 0) begin
                    bus.rsp_ready_i = 1'b1;
                    r_done = 1'b1;
                end else begin
                    rdy_cnt--;
                end
            end
        end
        @(posedge clk);  // response handshake edge
        @(negedge clk);
        bus.rsp_ready_i  = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        r_nreads = rd;
        check({name, ".done"}, {31'd0, r_done}, 32'd1);
        check({name, ".ready_after"}, {31'd0, bus.req_ready_o}, 32'd1);
        check({name, ".valid_after"}, {31'd0, bus.rsp_valid_o}, 32'd0);
    endtask

    task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input int gnt_dly1, input int rdy_dly,
                           input int e_cycle, input logic [31:0] e_data, input logic e_err,
                           input int e_nreads, input logic [31:0] e_a0, input logic [31:0] e_a1);
        run_load(name, addr, size, uns, gnt_dly1, rdy_dly);
        check({name, ".cycle"},  r_cycle, e_cycle);
        check({name, ".data"},   r_data, e_data);
        check({name, ".err"},    {31'd0, r_err}, {31'd0, e_err});
        check({name, ".nreads"}, r_nreads, e_nreads);
        check({name, ".stable"}, {31'd0, r_unstable}, 32'd0);
        if (e_nreads >= 1) check({name, ".addr0"}, r_addr0, e_a0);
        if (e_nreads >= 2) check({name, ".addr1"}, r_addr1, e_a1);
    endtask

    initial begin
        logic seen;
        bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_size_i = '0;
        bus.req_unsigned_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = '0; bus.rsp_ready_i = 1'b0;
        mem_a0 = '0; mem_d0 = '0; mem_a1 = '0; mem_d1 = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst.req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst.mem_req",   {31'd0, bus.mem_req_o},   32'd0);
        check("rst.mem_addr",  bus.mem_addr_o,           32'd0);
        check("rst.rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst.rsp_data",  bus.rsp_data_o,           32'd0);
        check("rst.rsp_err",   {31'd0, bus.rsp_err_o},   32'd0);
        check("rst.busy",      {31'd0, bus.busy_o},      32'd0);

        // aligned, single-read accesses on word 0x80AB_CD12
        mem_a0 = 32'h1000; mem_d0 = 32'h80AB_CD12; mem_a1 = 32'hFFFF_0000; mem_d1 = '0;
        do_load("lb",  32'h1003, 2'b00, 1'b0, 0, 0, 3, 32'hFFFF_FF80, 1'b0, 1, 32'h1000, 32'h0);
        do_load("lbu", 32'h1001, 2'b00, 1'b1, 0, 0, 3, 32'h0000_00CD, 1'b0, 1, 32'h1000, 32'h0);
        do_load("lh",  32'h1002, 2'b01, 1'b0, 0, 0, 3, 32'hFFFF_80AB, 1'b0, 1, 32'h1000, 32'h0);
        do_load("lw",  32'h1000, 2'b10, 1'b0, 0, 0, 3, 32'h80AB_CD12, 1'b0, 1, 32'h1000, 32'h0);

        // unsigned half with 4 cycles of response backpressure
        mem_a0 = 32'h2000; mem_d0 = 32'hBEEF_1234;
        do_load("lhu_bp", 32'h2002, 2'b01, 1'b1, 0, 4, 3, 32'h0000_BEEF, 1'b0, 1, 32'h2000, 32'h0);

        // word-crossing accesses
        mem_a0 = 32'h3000; mem_d0 = 32'h4433_2211; mem_a1 = 32'h3004; mem_d1 = 32'h8877_6655;
`ifdef MISALIGN_SPLIT_EN
        do_load("lw_split", 32'h3001, 2'b10, 1'b0, 2, 0, 7, 32'h5544_3322, 1'b0, 2, 32'h3000, 32'h3004);
        do_load("lh_split", 32'h3003, 2'b01, 1'b0, 0, 0, 5, 32'h0000_5544, 1'b0, 2, 32'h3000, 32'h3004);
`else
        do_load("lw_split", 32'h3001, 2'b10, 1'b0, 2, 0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_load("lh_split", 32'h3003, 2'b01, 1'b0, 0, 0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
`endif

        // crossing access at the top of the address space wraps to 0
        mem_a0 = 32'hFFFF_FFFC; mem_d0 = 32'hAABB_CCDD; mem_a1 = 32'h0; mem_d1 = 32'h1122_3344;
`ifdef MISALIGN_SPLIT_EN
        do_load("lw_wrap", 32'hFFFF_FFFE, 2'b10, 1'b0, 0, 0, 5, 32'h3344_AABB, 1'b0, 2,
                32'hFFFF_FFFC, 32'h0);
`else
        do_load("lw_wrap", 32'hFFFF_FFFE, 2'b10, 1'b0, 0, 0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
`endif

        // illegal size: immediate error, no memory access
        do_load("illegal", 32'h5000, 2'b11, 1'b0, 0, 0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);

        // reset while waiting for read data
        mem_a0 = 32'h4000; mem_d0 = 32'h1234_5678;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h4000;
        bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("mid.mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        bus.mem_gnt_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        check("mid.busy_wait0", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid.req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("mid.mem_req0",  {31'd0, bus.mem_req_o},   32'd0);
        check("mid.mem_addr",  bus.mem_addr_o,           32'd0);
        check("mid.rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("mid.rsp_data",  bus.rsp_data_o,           32'd0);
        check("mid.rsp_err",   {31'd0, bus.rsp_err_o},   32'd0);
        check("mid.busy",      {31'd0, bus.busy_o},      32'd0);
        bus.mem_rvalid_i = 1'b1;  // stale read data after reset
        bus.mem_rdata_i  = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mem_rvalid_i = 1'b0;
            if (bus.rsp_valid_o || bus.mem_req_o || bus.busy_o) seen = 1'b1;
        end
        check("mid.late_ignored", {31'd0, seen}, 32'd0);

        // normal operation resumes after the reset
        mem_a0 = 32'h1000; mem_d0 = 32'h80AB_CD12;
        do_load("post_rst", 32'h1000, 2'b00, 1'b1, 0, 0, 3, 32'h0000_0012, 1'b0, 1, 32'h1000, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
